// File: rtl/julia_pixel_writer.sv
// Julia pixel writer: buffers engine pixel writes and replays them as Avalon-MM single writes.
// Accept-to-master_write >= 1 cycle; in_ready falls when the FIFO is full (DEPTH + output register in flight).

module julia_pixel_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             toplevel_reset,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_dat = mem_q[rd_ptr_q[PW-1:0]];
  assign do_push  = push_vld && !full && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge toplevel_reset) begin
    if (!toplevel_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_dat;
  end

endmodule

module julia_pixel_writer #(
  parameter int unsigned      ADDRW        = 32,
  parameter int unsigned      DATAW        = 32,
  parameter int unsigned      DEPTH        = 16,
  parameter logic [ADDRW-1:0] BASE_ADDR    = 32'h08000000,
  parameter int unsigned      FRAME_PIXELS = 307200
) (
  input  logic             clk,
  input  logic             toplevel_reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [ADDRW-1:0] in_addr,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic [ADDRW-1:0] master_address,
  output logic [DATAW-1:0] master_writedata,
  output logic             master_write,
  input  logic             master_waitrequest,
  output logic [31:0]      pixel_count,
  output logic             frame_done,
  output logic             addr_err,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] dat;
  } pix_wr_t;

  // Range bounds carry two extra bits so BASE + 4*FRAME_PIXELS cannot wrap.
  localparam logic [ADDRW+1:0] ADDR_LO   = (ADDRW+2)'(BASE_ADDR);
  localparam logic [ADDRW+1:0] ADDR_HI   = ADDR_LO + (ADDRW+2)'(64'(FRAME_PIXELS) * 64'd4);
  localparam logic [31:0]      FRAME_CNT = 32'(FRAME_PIXELS);

  state_t      state_q, state_d;
  pix_wr_t     mst_q, mst_d;
  logic        mst_vld_q, mst_vld_d;
  logic        stale_q, stale_d;
  logic [31:0] pixel_count_q, pixel_count_d;
  logic        addr_err_q, addr_err_d;

  pix_wr_t     push_dat, head_dat;
  logic        fifo_empty, fifo_full;
  logic        accept, legal, push_vld, load, slave_take, count_en;
  logic [ADDRW+1:0] addr_x;

  assign addr_x     = {2'b00, in_addr};
  assign legal      = (addr_x >= ADDR_LO) && (addr_x < ADDR_HI);
  assign accept     = in_valid && in_ready;
  assign push_vld   = accept && legal;
  assign push_dat   = '{addr: in_addr, dat: in_data};
  assign slave_take = mst_vld_q && !master_waitrequest;
  // Nothing is loaded in the start cycle: the FIFO contents are being discarded.
  assign load       = !start && !fifo_empty && (!mst_vld_q || !master_waitrequest);
  // A write held across a start belongs to the old frame and is never counted.
  assign count_en   = (state_q == RUN) && slave_take && !stale_q && !start &&
                      (pixel_count_q < FRAME_CNT);

  julia_pixel_fifo #(
    .WIDTH ($bits(pix_wr_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk            (clk),
    .toplevel_reset (toplevel_reset),
    .flush          (start),
    .push_vld       (push_vld),
    .push_dat       (push_dat),
    .pop            (load),
    .head_dat       (head_dat),
    .empty          (fifo_empty),
    .full           (fifo_full)
  );

  always_ff @(posedge clk or negedge toplevel_reset) begin
    if (!toplevel_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (count_en && (pixel_count_q == FRAME_CNT - 32'd1)) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      RUN: begin
        in_ready = !fifo_full && !start;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  always_comb begin
    mst_d         = mst_q;
    mst_vld_d     = mst_vld_q;
    stale_d       = stale_q;
    pixel_count_d = pixel_count_q;
    addr_err_d    = addr_err_q;

    if (load) begin
      mst_d     = head_dat;
      mst_vld_d = 1'b1;
    end else if (!master_waitrequest) begin
      mst_vld_d = 1'b0;
    end

    if (start) begin
      stale_d       = mst_vld_q && master_waitrequest;
      pixel_count_d = '0;
      addr_err_d    = 1'b0;
    end else begin
      if (slave_take) stale_d = 1'b0;
      if (count_en) pixel_count_d = pixel_count_q + 32'd1;
      if (accept && !legal) addr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge toplevel_reset) begin
    if (!toplevel_reset) begin
      mst_q         <= '0;
      mst_vld_q     <= 1'b0;
      stale_q       <= 1'b0;
      pixel_count_q <= '0;
      addr_err_q    <= 1'b0;
    end else begin
      mst_q         <= mst_d;
      mst_vld_q     <= mst_vld_d;
      stale_q       <= stale_d;
      pixel_count_q <= pixel_count_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign master_address   = mst_q.addr;
  assign master_writedata = mst_q.dat;
  assign master_write     = mst_vld_q;
  assign pixel_count      = pixel_count_q;
  assign frame_done       = (pixel_count_q == FRAME_CNT);
  assign addr_err         = addr_err_q;

endmodule

// File: tb/tb_julia_pixel_writer.sv
// Bench for julia_pixel_writer: directed scenarios plus a randomized run against a queue-based model.
module tb_julia_pixel_writer;

  localparam int          DEPTH = 4;
  localparam int          FP    = 8;
  localparam logic [31:0] BASE  = 32'h08000000;
  localparam int          S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [31:0] master_address, master_writedata;
  logic        master_write;
  logic        wr = 1'b0;
  logic [31:0] pixel_count;
  logic        frame_done, addr_err, busy;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO as a queue, the output register as a slot.
  int          m_state;
  logic [63:0] m_fifo[$];
  bit          m_reg_vld;
  logic [31:0] m_reg_addr, m_reg_data;
  bit          m_stale;
  int          m_cnt;
  bit          m_err;

  julia_pixel_writer #(
    .ADDRW(32), .DATAW(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .FRAME_PIXELS(FP)
  ) dut (
    .clk(clk), .toplevel_reset(rst_n), .start(start), .in_valid(in_valid),
    .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
    .master_address(master_address), .master_writedata(master_writedata),
    .master_write(master_write), .master_waitrequest(wr),
    .pixel_count(pixel_count), .frame_done(frame_done), .addr_err(addr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit legal(input logic [31:0] a);
    longint unsigned x;
    x = a;
    return (x >= BASE) && (x < longint'(BASE) + 4 * FP);
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_fifo.delete(); m_reg_vld = 0; m_reg_addr = 0; m_reg_data = 0;
    m_stale = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit rdy, acc, take, inc;
    rdy  = (m_state == S_RUN) && !start && (m_fifo.size() < DEPTH);
    acc  = in_valid && rdy;
    take = m_reg_vld && !wr;
    inc  = take && (m_state == S_RUN) && !m_stale && !start && (m_cnt < FP);
    if (start) begin
      m_stale = m_reg_vld && wr;
      if (take) m_reg_vld = 0;
      m_fifo.delete();
      m_cnt = 0; m_err = 0; m_state = S_RUN;
    end else begin
      if (take) begin m_stale = 0; m_reg_vld = 0; end
      if (!m_reg_vld && m_fifo.size() > 0) begin
        {m_reg_addr, m_reg_data} = m_fifo.pop_front();
        m_reg_vld = 1;
      end
      if (acc) begin
        if (legal(in_addr)) m_fifo.push_back({in_addr, in_data});
        else m_err = 1;
      end
      if (inc) begin
        m_cnt++;
        if (m_cnt == FP) m_state = S_DONE;
      end
    end
  endtask

  task automatic adv();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic v, input logic [31:0] a,
                        input logic [31:0] d, input logic w);
    start = s; in_valid = v; in_addr = a; in_data = d; wr = w;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    total++;
    if ({in_ready, master_write, master_address, master_writedata, pixel_count,
         frame_done, addr_err, busy} !== '0) begin
      bad++; $display("FAIL reset_outputs: got mw=%0b rdy=%0b cnt=%0d busy=%0b, want all 0",
                      master_write, in_ready, pixel_count, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_in(0, 1, BASE, 32'h1, 0);
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || master_write !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL idle_quiet: rdy=%0b mw=%0b busy=%0b, want 0 0 0", in_ready, master_write, busy);
      end
      adv();
    end
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic test_frame();
    int i = 0, j = 0, first_c = -1;
    bit done_chk = 0;
    set_in(1, 0, 0, 0, 0);
    @(negedge clk); adv();
    for (int c = 0; c < 40 && !done_chk; c++) begin
      set_in(0, (i < FP), BASE + 4 * i, i, 0);
      @(negedge clk);
      if (j == FP) begin
        total++;
        if (frame_done !== 1'b1 || pixel_count !== FP || in_ready !== 1'b0) begin
          bad++; $display("FAIL frame_end: done=%0b cnt=%0d rdy=%0b, want 1 %0d 0", frame_done, pixel_count, in_ready, FP);
        end
        done_chk = 1;
      end
      if (first_c >= 0 && c == first_c + 1) begin
        total++;
        if (master_write !== 1'b0) begin bad++; $display("FAIL first_latency: mw=%0b want 0", master_write); end
      end
      if (master_write && !wr && j < FP) begin
        total++;
        if (master_address !== BASE + 4 * j || master_writedata !== j) begin
          bad++; $display("FAIL frame_order: addr=%h data=%0d, want %h %0d", master_address, master_writedata, BASE + 4 * j, j);
        end
        j++;
        if (j == FP) begin
          total++;
          if (frame_done !== 1'b0) begin bad++; $display("FAIL frame_done_early: got 1 want 0"); end
        end
      end
      if (in_valid && in_ready) begin
        if (first_c < 0) first_c = c;
        i++;
      end
      adv();
    end
    total++;
    if (!done_chk) begin bad++; $display("FAIL frame_timeout: writes seen %0d want %0d", j, FP); end
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic last_rdy = 1'b1;
    set_in(1, 0, 0, 0, 1);
    @(negedge clk); adv();
    for (int c = 0; c < 12; c++) begin
      set_in(0, 1, BASE + 4 * acc, 100 + acc, 1);
      @(negedge clk);
      if (master_write) begin
        total++;
        if (master_address !== BASE) begin bad++; $display("FAIL held_addr: %h want %h", master_address, BASE); end
      end
      last_rdy = in_ready;
      if (in_ready) acc++;
      adv();
    end
    total++;
    if (acc !== DEPTH + 1 || last_rdy !== 1'b0) begin
      bad++; $display("FAIL capacity: accepts=%0d rdy=%0b, want %0d 0", acc, last_rdy, DEPTH + 1);
    end
    for (int k = 0; k < DEPTH + 1; k++) begin
      set_in(0, 0, 0, 0, 0);
      @(negedge clk);
      total++;
      if (master_write !== 1'b1 || master_address !== BASE + 4 * k || master_writedata !== 100 + k) begin
        bad++; $display("FAIL drain_%0d: mw=%0b addr=%h data=%0d, want 1 %h %0d",
                        k, master_write, master_address, master_writedata, BASE + 4 * k, 100 + k);
      end
      adv();
    end
    @(negedge clk);
    total++;
    if (master_write !== 1'b0 || pixel_count !== DEPTH + 1) begin
      bad++; $display("FAIL drain_end: mw=%0b cnt=%0d, want 0 %0d", master_write, pixel_count, DEPTH + 1);
    end
    adv();
  endtask

  task automatic test_addr_err();
    set_in(1, 0, 0, 0, 0);
    @(negedge clk); adv();
    set_in(0, 1, BASE + 4 * FP, 32'hdead, 0);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL illegal_handshake: rdy=%0b want 1", in_ready); end
    adv();
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0, 0, 0);
      @(negedge clk);
      total++;
      if (master_write !== 1'b0 || addr_err !== 1'b1 || pixel_count !== 0) begin
        bad++; $display("FAIL illegal_drop: mw=%0b err=%0b cnt=%0d, want 0 1 0", master_write, addr_err, pixel_count);
      end
      adv();
    end
    set_in(0, 1, BASE + 4 * (FP - 1), 32'h55, 0);
    @(negedge clk); adv();
    set_in(0, 0, 0, 0, 0);
    @(negedge clk); adv();
    @(negedge clk);
    total++;
    if (master_write !== 1'b1 || master_address !== BASE + 4 * (FP - 1) || master_writedata !== 32'h55) begin
      bad++; $display("FAIL last_legal: mw=%0b addr=%h data=%h, want 1 %h 55", master_write, master_address, master_writedata, BASE + 4 * (FP - 1));
    end
    adv();
    @(negedge clk);
    total++;
    if (pixel_count !== 1 || addr_err !== 1'b1) begin
      bad++; $display("FAIL after_legal: cnt=%0d err=%0b, want 1 1", pixel_count, addr_err);
    end
    adv();
  endtask

  task automatic test_mid_start();
    set_in(1, 0, 0, 0, 0);
    @(negedge clk); adv();
    set_in(0, 1, BASE - 4, 32'h9, 0);
    @(negedge clk); adv();
    set_in(0, 1, BASE, 32'h1, 0);
    @(negedge clk); adv();
    set_in(0, 0, 0, 0, 0);
    @(negedge clk); adv();
    @(negedge clk); adv();
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1, BASE + 4 + 4 * k, 32'h200 + k, 1);
      @(negedge clk); adv();
    end
    set_in(1, 1, BASE + 32'h40, 32'h7, 1);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || pixel_count !== 1 || addr_err !== 1'b1 || master_write !== 1'b1) begin
      bad++; $display("FAIL pre_start: rdy=%0b cnt=%0d err=%0b mw=%0b, want 0 1 1 1", in_ready, pixel_count, addr_err, master_write);
    end
    adv();
    for (int c = 0; c < 4; c++) begin
      set_in(0, 0, 0, 0, (c < 3));
      @(negedge clk);
      total++;
      if (master_write !== 1'b1 || master_address !== BASE + 4 || master_writedata !== 32'h200 ||
          pixel_count !== 0 || addr_err !== 1'b0) begin
        bad++; $display("FAIL held_across_start: mw=%0b addr=%h data=%h cnt=%0d err=%0b, want 1 %h 200 0 0",
                        master_write, master_address, master_writedata, pixel_count, addr_err, BASE + 4);
      end
      adv();
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (master_write !== 1'b0 || pixel_count !== 0 || busy !== 1'b1) begin
        bad++; $display("FAIL flushed: mw=%0b cnt=%0d busy=%0b, want 0 0 1", master_write, pixel_count, busy);
      end
      adv();
    end
  endtask

  task automatic test_reset_mid_drain();
    set_in(1, 0, 0, 0, 1);
    @(negedge clk); adv();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, BASE + 4 * k, k, 1);
      @(negedge clk); adv();
    end
    set_in(0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (master_write !== 1'b1) begin bad++; $display("FAIL drain_active: mw=%0b want 1", master_write); end
    adv();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, master_write, master_address, master_writedata, pixel_count,
         frame_done, addr_err, busy} !== '0) begin
      bad++; $display("FAIL async_reset: mw=%0b addr=%h cnt=%0d busy=%0b, want all 0",
                      master_write, master_address, pixel_count, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(0, 1, BASE, 32'h3, 0);
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || master_write !== 1'b0) begin
        bad++; $display("FAIL post_reset_idle: busy=%0b rdy=%0b mw=%0b, want 0 0 0", busy, in_ready, master_write);
      end
      adv();
    end
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    bit exp_rdy;
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = BASE + 4 * FP + 4 * $urandom_range(0, 3);
      else if (r == 1) a = BASE - 4 * $urandom_range(1, 4);
      else if (r == 2) a = $urandom;
      else             a = BASE + 4 * $urandom_range(0, FP - 1);
      set_in(($urandom_range(0, 39) == 0) || (m_state != S_RUN && $urandom_range(0, 4) == 0),
             ($urandom_range(0, 9) < 7), a, $urandom, ($urandom_range(0, 9) < 4));
      @(negedge clk);
      exp_rdy = (m_state == S_RUN) && !start && (m_fifo.size() < DEPTH);
      total++;
      if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_in_ready c=%0d: %0b want %0b", c, in_ready, exp_rdy); end
      total++;
      if (master_write !== m_reg_vld) begin bad++; $display("FAIL rnd_master_write c=%0d: %0b want %0b", c, master_write, m_reg_vld); end
      if (m_reg_vld) begin
        total++;
        if (master_address !== m_reg_addr || master_writedata !== m_reg_data) begin
          bad++; $display("FAIL rnd_payload c=%0d: %h/%h want %h/%h", c, master_address, master_writedata, m_reg_addr, m_reg_data);
        end
      end
      total++;
      if (pixel_count !== m_cnt || frame_done !== (m_cnt == FP)) begin
        bad++; $display("FAIL rnd_count c=%0d: cnt=%0d done=%0b want %0d %0b", c, pixel_count, frame_done, m_cnt, (m_cnt == FP));
      end
      total++;
      if (addr_err !== m_err || busy !== (m_state == S_RUN)) begin
        bad++; $display("FAIL rnd_flags c=%0d: err=%0b busy=%0b want %0b %0b", c, addr_err, busy, m_err, (m_state == S_RUN));
      end
      adv();
    end
    set_in(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_addr_err();
    test_mid_start();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/julia_pixel_writer.md
Name: julia_pixel_writer

Overview:
- Downstream stage of the Julia pixel engine; sits between the engine's pixel-write output and the SDRAM Avalon-MM master port.
- Buffers pixel writes in a FIFO and issues Avalon-MM single writes that honour master_waitrequest.
- Counts completed writes and flags frame completion and address errors.
- Lets the engine run at full rate while SDRAM stalls intermittently.

Parameters:
- ADDRW, 32, address width of input and master port
- DATAW, 32, pixel data width
- DEPTH, 16, FIFO entries (power of two, >=2)
- BASE_ADDR, 32'h08000000, first legal byte address of frame buffer
- FRAME_PIXELS, 307200, writes per frame (640x480)

Ports:
- clk  in  1  clock
- toplevel_reset  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse: arm/restart frame
- in_valid  in  1  engine presents a pixel write
- in_addr  in  ADDRW  byte address of pixel
- in_data  in  DATAW  pixel value
- in_ready  out  1  write accepted this cycle when in_valid&&in_ready
- master_address  out  ADDRW  Avalon address
- master_writedata  out  DATAW  Avalon write data
- master_write  out  1  Avalon write request
- master_waitrequest  in  1  Avalon stall
- pixel_count  out  32  completed (accepted-by-slave) writes this frame
- frame_done  out  1  level, pixel_count==FRAME_PIXELS
- addr_err  out  1  sticky, out-of-range write dropped
- busy  out  1  state==RUN

Behaviour:
- Reset (async, toplevel_reset=0): state IDLE; FIFO empty; all outputs 0 (in_ready, master_write, master_address, master_writedata, pixel_count, frame_done, addr_err, busy). master_write drops immediately on reset assertion.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=0. start -> RUN.
  - RUN: in_ready=!fifo_full. Goes to DONE on the edge where the completed write makes pixel_count reach FRAME_PIXELS.
  - DONE: in_ready=0; frame_done=1; start -> RUN.
- start in any state:
  - Clears pixel_count, addr_err and frame_done; flushes the FIFO; enters RUN on the next edge.
  - A write held on the master port (master_write=1, waitrequest=1) stays held, with address and data stable, until accepted.
  - That held write is not counted.
  - in_ready=0 in the start cycle.
- Accept rule:
  - Push on in_valid&&in_ready.
  - in_ready is computed from FIFO occupancy at the start of the cycle. No push when full, even with a simultaneous pop.
- Range check at accept: legal iff BASE_ADDR <= in_addr < BASE_ADDR+4*FRAME_PIXELS, compared unsigned in ADDRW+2 bits to avoid wrap.
  - Illegal: entry is not pushed; addr_err <= 1 (sticky until start/reset); handshake still completes.
- Master port:
  - Output register stage holds address, data and master_write.
  - Load from FIFO head when the FIFO is non-empty and (master_write==0 or waitrequest==0).
  - Otherwise clear master_write if waitrequest==0, or hold if waitrequest==1.
  - Address and data never change while master_write && waitrequest.
- Latency: a write accepted at edge k is visible on master_write after edge k+1 at the earliest. Back-to-back writes issue one per cycle when waitrequest=0.
- Capacity: DEPTH FIFO entries plus 1 output register. With waitrequest stuck high, DEPTH+1 writes are accepted before in_ready drops.
- Ordering: strictly FIFO; data and address unchanged.
- Counting:
  - pixel_count increments on each cycle with master_write&&!waitrequest, in RUN only.
  - Saturates at FRAME_PIXELS.
  - Any entries still buffered after DONE are drained but not counted.
- Pointers: log2(DEPTH) bits plus an extra wrap bit for full/empty; wrap-around is natural modulo.

Test Plan:
- Reset, then idle 5 cycles with in_valid=1 -> all outputs 0, no master_write, in_ready=0.
- DEPTH=4, FRAME_PIXELS=8, start, 8 writes to addr 0x08000000+4i with data i, waitrequest=0 -> 8 master writes in order with matching addr/data; pixel_count=8; frame_done=1 one edge after the 8th accepted write; in_ready=0 afterwards.
- Same config, waitrequest=1 for 12 cycles with in_valid continuously high -> exactly 5 accepts then in_ready=0; master_address=0x08000000 stable throughout; releasing waitrequest drains all 5 writes in order at 1/cycle.
- Write to 0x08000020 (FRAME_PIXELS=8, first illegal address) -> no master_write, addr_err=1, pixel_count unchanged; the next legal write proceeds normally.
- Mid-frame start with master_write held (waitrequest=1) and 3 entries buffered -> held write stays stable until waitrequest=0 then completes; buffered entries discarded; pixel_count=0; addr_err=0.
- Assert toplevel_reset mid-drain, async between edges -> master_write and all outputs 0 immediately; after release, state IDLE.
